mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_ctrl.sv | 107 ++++++++++
 tb/tb_mul_seq_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: 8x8 unsigned sequential multiplier. It uses shift-add through
// one 8-bit ripple adder that has an explicit carry-in and carry-out.
//
// Ports:
//   clk      in   1   single clock; all state changes on its rising edge
//   rst      in   1   synchronous active-high reset
//   start    in   1   begin a multiply; sampled only while idle
//   a        in   8   multiplicand (unsigned), captured on the accepting edge
//   b        in   8   multiplier (unsigned), captured on the accepting edge
//   busy     out  1   high while an operation is running or completing
//   done     out  1   one-cycle pulse; product is valid while it is high
//   product  out  16  registered a*b; holds until the next completion
//
// Timing: start accepted at edge k -> 8 RUN cycles -> done high after edge
// k+8 -> idle after edge k+9. A new start can be accepted at edge k+10.

module mul_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [7:0]  mcand;
    logic [7:0]  acc_hi;
    logic [7:0]  acc_lo;
    logic [2:0]  cnt;

    // The single adder and its operands.
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        cin;
    logic [7:0]  sum;
    logic        cout;
    logic        carry;
    logic [15:0] shifted;

    // When the multiplier bit is 0, adding zero yields {0, acc_hi}.
    // That matches the "no add" case, so no bypass mux is needed.
    assign add_a = acc_hi;
    assign add_b = acc_lo[0] ? mcand : '0;
    assign cin   = 1'b0;

    always_comb begin
        sum   = '0;
        carry = cin;
        for (int unsigned i = 0; i < 8; i++) begin
            sum[i] = add_a[i] ^ add_b[i] ^ carry;
            carry  = (add_a[i] & add_b[i]) | (carry & (add_a[i] ^ add_b[i]));
        end
        cout = carry;
    end

    // The carry-out moves into acc_hi[7] on the shift, so it is never lost.
    assign shifted = {cout, sum, acc_lo[7:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        acc_hi <= '0;
                        acc_lo <= b;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc_hi <= shifted[15:8];
                    acc_lo <= shifted[7:0];
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        product <= shifted;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl. A behavioural model counts down the
// cycles left in an operation and holds the pending a*b. Every negedge it is
// compared with the DUT. Directed cases also check hand-computed values.

module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_assert = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    // Behavioural model. rem is the number of cycles left in the current
    // operation (0 means idle). It is 9 right after acceptance and 1 in the
    // done cycle.
    int          rem = 0;
    logic [15:0] m_pend = '0;
    logic [15:0] m_prod = '0;
    int          ops_done = 0;

    mul_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            rem    = 0;
            m_prod = '0;
        end else if (rem == 0) begin
            if (start) begin
                rem    = 9;
                m_pend = 16'(a) * 16'(b);
            end
        end else begin
            if (rem == 2) begin
                m_prod   = m_pend;
                ops_done = ops_done + 1;
            end
            rem = rem - 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_assert = n_assert + 3;
            if (busy !== (rem != 0)) begin
                n_fail = n_fail + 1;
                $display("FAIL busy t=%0t got=%b want=%b", $time, busy, rem != 0);
            end
            if (done !== (rem == 1)) begin
                n_fail = n_fail + 1;
                $display("FAIL done t=%0t got=%b want=%b", $time, done, rem == 1);
            end
            if (product !== m_prod) begin
                n_fail = n_fail + 1;
                $display("FAIL product t=%0t got=%h want=%h", $time, product, m_prod);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_assert = n_assert + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Start an op from idle. Wait for done, then check latency and result.
    // done must be seen right after edge k+8, i.e. it is high at edge k+9.
    task automatic run_op(input string name, input logic [7:0] ia, input logic [7:0] ib,
                          input logic [15:0] want);
        int n;
        @(negedge clk);
        start = 1'b1; a = ia; b = ib;
        @(negedge clk);
        start = 1'b0; a = $urandom_range(0, 255); b = $urandom_range(0, 255);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        check({name, "_latency"}, 16'(n), 16'd8);
        check(name, product, want);
    endtask

    initial begin
        int offs[$];
        int n;

        // Reset for two cycles.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_product", product, 16'h0000);

        run_op("op_0d_0b", 8'h0D, 8'h0B, 16'h008F);
        run_op("op_ff_ff", 8'hFF, 8'hFF, 16'hFE01);
        run_op("op_00_ff", 8'h00, 8'hFF, 16'h0000);
        run_op("op_80_02", 8'h80, 8'h02, 16'h0100);

        // Hold start for 30 cycles. Done should appear after edges +8, +18
        // and +28 counted from the first accepting edge.
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h10;
        @(negedge clk);
        for (int j = 0; j < 30; j++) begin
            if (j > 0) @(negedge clk);
            if (done === 1'b1) begin
                offs.push_back(j);
                check("hold_product", product, 16'h0100);
            end
        end
        start = 1'b0;
        check("hold_count", 16'(offs.size()), 16'd3);
        if (offs.size() == 3) begin
            check("hold_off0", 16'(offs[0]), 16'd8);
            check("hold_off1", 16'(offs[1]), 16'd18);
            check("hold_off2", 16'(offs[2]), 16'd28);
        end
        @(negedge clk);

        // Change a/b and pulse start during RUN. Both should be ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h07; b = 8'h09;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            a = 8'hFF; b = 8'hEE; start = (j == 1);
        end
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        check("ignore_product", product, 16'h003F);
        @(negedge clk);

        // Assert reset in the 4th RUN cycle, then run a fresh op.
        @(negedge clk);
        start = 1'b1; a = 8'h55; b = 8'h77;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 3; j++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_product", product, 16'h0000);
        for (int j = 0; j < 12; j++) @(negedge clk);
        check("abort_product_later", product, 16'h0000);
        run_op("after_abort", 8'h03, 8'h05, 16'h000F);
        @(negedge clk);

        // Random traffic. Start is toggled freely and a/b change every cycle;
        // the model decides what is accepted.
        n = ops_done + 1000;
        for (int cyc = 0; cyc < 15000 && ops_done < n; cyc++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
        end
        start = 1'b0;
        check("random_ops_done", 16'(ops_done >= n), 16'd1);
        for (int j = 0; j < 12; j++) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
